// File: rtl/vreg_lane_reader.sv
// Captures a W-bit register value on start and streams it out as W/LANE lanes over valid/ready.
// Lane order is LSB lane first; defining VREG_LANE_MSB_FIRST_EN streams the MSB lane first.
module vreg_lane_reader #(
  parameter int W    = 128,
  parameter int LANE = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [W-1:0]    src_data_i,
  output logic            busy_o,
  output logic [LANE-1:0] out_data_o,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic            out_last_o,
  output logic            done_o
);

  localparam int NL = W / LANE;
  localparam int IW = $clog2(NL);
  localparam logic [IW-1:0] IDX_LAST = IW'(NL - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  buf_q, buf_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [NL-1:0][LANE-1:0] lanes;
  logic [LANE-1:0]         lane_sel;
  logic                    sending;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_SEND;
          buf_d   = src_data_i;
          idx_d   = '0;
        end
      end
      S_SEND: begin
        if (out_ready_i) begin
          // Index is parked at zero on the final accept so it never passes NL-1.
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
    end
  end

  assign lanes = buf_q;

  always_comb begin
`ifdef VREG_LANE_MSB_FIRST_EN
    lane_sel = lanes[IDX_LAST - idx_q];
`else
    lane_sel = lanes[idx_q];
`endif
  end

  // Outputs depend only on registered state, so an async reset clears them at once.
  assign sending     = (state_q == S_SEND);
  assign out_valid_o = sending;
  assign out_data_o  = sending ? lane_sel : '0;
  assign out_last_o  = sending && (idx_q == IDX_LAST);
  assign done_o      = (state_q == S_DONE);
  assign busy_o      = (state_q != S_IDLE);

endmodule
